// File: rtl/device_tick_pkg.sv
// Shared types for the multi-channel tick generator.
package device_tick_pkg;

  typedef enum logic {PERIODIC = 1'b0, ONESHOT = 1'b1} tick_mode_e;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} tick_state_e;

endpackage

// File: rtl/device_tick_chan.sv
// One tick channel: divisor/mode registers, free counter, IDLE/RUN state and tick decode.
module device_tick_chan
  import device_tick_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 10000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             sync,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_mode,
  input  logic             cfg_en,
  output logic             tick,
  output logic             busy
);

  tick_state_e      state_q, state_d;
  tick_mode_e       mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             hit;

  // Decoded from registers only so downstream enables see no input-to-output path.
  assign hit  = (state_q == RUN) && (cnt_q == div_q);
  assign tick = hit;
  assign busy = (state_q == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      mode_q  <= PERIODIC;
      div_q   <= DIV_W'(DEFAULT_DIV);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    if (wr) begin
      div_d   = cfg_div;
      mode_d  = tick_mode_e'(cfg_mode);
      cnt_d   = '0;
      state_d = cfg_en ? RUN : IDLE;
    end else if (state_q == RUN) begin
      // A wrap and a sync both land on zero, so a sync during the tick cycle adds no tick.
      if (hit) begin
        cnt_d = '0;
        if (mode_q == ONESHOT) state_d = IDLE;
      end else if (sync) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/device_tick_gen.sv
// Multi-channel programmable tick generator: channel-select decode plus one channel per index.
module device_tick_gen
  import device_tick_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 10000,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic                cfg_mode,
  input  logic                cfg_en,
  input  logic                sync,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] busy
);

  logic [CHANNELS-1:0] wr;

  // Indices at or beyond CHANNELS match no channel, so such writes fall away.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign wr[i] = cfg_wr && (cfg_ch == CH_W'(i));

    device_tick_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr       (wr[i]),
      .sync     (sync),
      .cfg_div  (cfg_div),
      .cfg_mode (cfg_mode),
      .cfg_en   (cfg_en),
      .tick     (tick[i]),
      .busy     (busy[i])
    );
  end

endmodule

// File: tb/tb_device_tick_gen.sv
// Directed bench: a schedule model pushes per-edge expectations, checked one cycle later.
module tb_device_tick_gen;
  localparam int CH = 5;
  localparam int DW = 16;
  localparam int DD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_wr;
  logic [2:0]    cfg_ch;
  logic [DW-1:0] cfg_div;
  logic          cfg_mode;
  logic          cfg_en;
  logic          sync;
  logic [CH-1:0] tick;
  logic [CH-1:0] busy;

  device_tick_gen #(.CHANNELS(CH), .DIV_W(DW), .DEFAULT_DIV(DD)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_mode(cfg_mode), .cfg_en(cfg_en), .sync(sync), .tick(tick), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] tick;
    logic [CH-1:0] busy;
    int            edge_n;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Schedule model: each channel tracks the edge number after which its next tick appears.
  int e;
  bit m_run[CH];
  bit m_os[CH];
  int m_d[CH];
  int m_next[CH];
  bit m_prev[CH];

  task automatic model_reset();
    e = 0;
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 1'b1; m_os[c] = 1'b0; m_d[c] = DD; m_next[c] = DD; m_prev[c] = 1'b0;
    end
  endtask

  task automatic model_edge();
    exp_t x;
    e++;
    for (int c = 0; c < CH; c++) begin
      if (m_prev[c]) begin
        if (m_os[c]) m_run[c] = 1'b0;
        else         m_next[c] = e + m_d[c];
      end
      if (sync && m_run[c]) m_next[c] = e + m_d[c];
      if (cfg_wr && int'(cfg_ch) == c) begin
        m_run[c] = cfg_en; m_os[c] = cfg_mode; m_d[c] = int'(cfg_div); m_next[c] = e + m_d[c];
      end
      x.tick[c] = m_run[c] && (m_next[c] == e);
      x.busy[c] = m_run[c];
      m_prev[c] = x.tick[c];
    end
    x.edge_n = e;
    q.push_back(x);
  endtask

  task automatic step();
    exp_t x;
    model_edge();
    @(posedge clk);
    #1;
    x = q.pop_front();
    n_cmp++;
    assert (tick === x.tick) else begin
      n_err++;
      $error("FAIL tick@edge%0d: observed %b expected %b", x.edge_n, tick, x.tick);
    end
    n_cmp++;
    assert (busy === x.busy) else begin
      n_err++;
      $error("FAIL busy@edge%0d: observed %b expected %b", x.edge_n, busy, x.busy);
    end
    cfg_wr = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write(input int ch, input int dv, input bit mode, input bit en);
    cfg_wr = 1'b1; cfg_ch = 3'(ch); cfg_div = DW'(dv); cfg_mode = mode; cfg_en = en;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    assert (tick === '0) else begin
      n_err++;
      $error("FAIL %s tick: observed %b expected %b", tag, tick, {CH{1'b0}});
    end
    n_cmp++;
    assert (busy === '1) else begin
      n_err++;
      $error("FAIL %s busy: observed %b expected %b", tag, busy, {CH{1'b1}});
    end
  endtask

  task automatic wait_tick_cycle(input int ch);
    for (int i = 0; i < 30 && !m_prev[ch]; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0;
    cfg_mode = 1'b0; cfg_en = 1'b0; sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("reset_release");

    // Free-running default divider: ticks after edges 4, 9, 14.
    steps(15);

    // ch1 periodic div 2.
    write(1, 2, 1'b0, 1'b1);
    steps(10);

    // ch2 one-shot div 3, then a long quiet window.
    write(2, 3, 1'b1, 1'b1);
    steps(25);

    // Rewrite ch0 during its tick cycle.
    wait_tick_cycle(0);
    write(0, 4, 1'b0, 1'b1);
    steps(12);

    // Stop ch3, ch1 to div 6, then sync.
    write(3, 0, 1'b0, 1'b0);
    step();
    write(1, 6, 1'b0, 1'b1);
    steps(3);
    sync = 1'b1;
    steps(16);

    // Sync landing in ch0's tick cycle.
    wait_tick_cycle(0);
    sync = 1'b1;
    steps(8);

    // One-shot expiry coinciding with an enabling write: write wins.
    write(2, 2, 1'b1, 1'b1);
    step();
    wait_tick_cycle(2);
    write(2, 3, 1'b0, 1'b1);
    steps(10);

    // Period 1 channel.
    write(4, 0, 1'b0, 1'b1);
    steps(5);

    // Out-of-range channel index.
    write(CH, 1, 1'b1, 1'b0);
    steps(10);

    // Asynchronous reset mid-count.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    steps(15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/device_tick_gen.md
# device_tick_gen

Multi-channel programmable clock-enable (tick) generator for the peripheral bus side of the CPU subsystem. Each channel emits a one-`clk`-cycle `tick` pulse every `div+1` cycles (periodic) or once after `div+1` cycles (one-shot). Divisor, mode and enable are runtime-programmable per channel, and a global `sync` realigns all running channels. Peripherals (UART baud, timers, debouncers) use `tick` as a clock enable, never as a clock.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent tick channels (1..16).
- `DIV_W`, 16: divisor/counter width.
- `DEFAULT_DIV`, 10000: divisor loaded at reset; must fit in `DIV_W`.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `cfg_wr`, in, 1: single-cycle configuration write strobe.
- `cfg_ch`, in, $clog2(CHANNELS) (min 1): target channel index.
- `cfg_div`, in, DIV_W: new divisor; tick period is `cfg_div+1`.
- `cfg_mode`, in, 1: 0 = periodic, 1 = one-shot.
- `cfg_en`, in, 1: 1 = start the channel, 0 = stop it.
- `sync`, in, 1: clear the counters of all running channels.
- `tick`, out, CHANNELS: per-channel one-cycle pulse.
- `busy`, out, CHANNELS: channel is in RUN.

## Operation
- Per-channel registers: `div_r[DIV_W]`, `mode_r`, `cnt[DIV_W]`, `state`.
- Per-channel states: IDLE and RUN.
  - RUN: `cnt` increments each cycle. When `cnt == div_r`, `tick` = 1 and `cnt` <= 0.
  - After that tick, periodic mode stays in RUN. One-shot mode goes to IDLE.
  - IDLE: `cnt` holds 0, `tick` = 0.
- `tick` = (state==RUN) && (cnt==div_r). It is decoded from registers only, with no combinational path from any input.
- `busy` = (state==RUN).
- Configuration write (`cfg_wr` with `cfg_ch < CHANNELS`):
  - Next cycle: `div_r` <= `cfg_div`, `mode_r` <= `cfg_mode`, `cnt` <= 0.
  - State goes to RUN if `cfg_en`, otherwise IDLE.
  - A write with `cfg_ch >= CHANNELS` is ignored entirely.
- `div` = 0 gives `tick` on every RUN cycle. Arithmetic wraps are impossible because `cnt` never exceeds `div_r`.
- `sync`: every channel in RUN gets `cnt` <= 0 next cycle. IDLE channels are unaffected.
- Priority for the addressed channel: `cfg_wr` > `sync` > normal count.
- Simultaneous events:
  - A channel at `cnt == div_r` during a `cfg_wr` or `sync` cycle still outputs `tick` in that cycle. The write/sync then takes effect, and no duplicate or extra tick follows.
  - A one-shot expiry in the same cycle as a `cfg_wr` with `cfg_en` = 1 to that channel: the write wins and the channel ends in RUN.
- Reset (asynchronous, any time, including mid-count): all channels go to RUN, periodic, `div_r` = DEFAULT_DIV, `cnt` = 0. This makes the block a drop-in free-running divider out of reset.
- Reset values of outputs: `tick` = 0. `busy` = all ones (`busy` reflects the RUN state).

## Timing
- Edges after the `rst_n` release are numbered 1, 2, …; `cnt` = k after edge k.
- Periodic with divisor D: `tick` is high in the cycle after edge D, then after edges 2D+1, 3D+2, … (period D+1).
- `cfg_wr` sampled at edge W, enabled, divisor D: `cnt` = 0 after W, and the first `tick` is in the cycle after edge W+D.
- `sync` sampled at edge S: the next tick of every running channel follows edge S+D.
- One-shot: exactly one `tick`. `busy` falls on the edge that ends the tick cycle.
- Latency from `cfg_wr` to `busy` change: 1 cycle.

## Structure
- Package `device_tick_pkg`:
  - `tick_mode_e` {PERIODIC, ONESHOT}.
  - `tick_state_e` {IDLE, RUN}.
- Sub-module `device_tick_chan`: one channel holding the counter, state, and tick/busy decode. It takes a local `wr` (already decoded), `sync`, and the cfg fields.
- Top level: `cfg_ch` decode plus a generate loop over `CHANNELS`.

## Test plan
- Reset, `DEFAULT_DIV` = 4, no writes -> `tick` on all channels after edges 4, 9, 14; `busy` = all ones.
- Write ch1 `div` = 2, periodic, en at edge W -> ch1 ticks after W+2, W+5, W+8; other channels undisturbed.
- Write ch2 `div` = 3, one-shot -> a single tick after W+3; `busy[2]` falls next edge; no further ticks for 20 cycles.
- Write ch0 while `cnt == div` -> tick still seen that cycle, then period restarts from 0 with new div; no double tick.
- ch0 `div` = 4 and ch1 `div` = 6 running, pulse `sync` at edge S -> ticks after S+4 and S+6; IDLE ch3 stays silent.
- `cfg_ch` = CHANNELS (out of range) write -> no state change. `rst_n` asserted mid-count -> outputs return to reset values immediately (asynchronously), default schedule resumes.
